// File: rtl/sprite_pkg.sv
// sprite_pkg: shared state, colour and pixel types plus default screen size for the sprite mover.
package sprite_pkg;
  typedef enum logic [2:0] {IDLE, DRAW, READY, ERASE, DRAIN, HOLD, EDGE} state_t;
  typedef logic [2:0] colour_t;
  localparam colour_t COLOUR_BLACK = 3'd0;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  typedef struct packed {
    logic       valid;
    logic [7:0] x;
    logic [6:0] y;
    logic       erase;
  } pix_t;
endpackage

// File: rtl/sprite_mover_pix_delay_line.sv
// pix_delay_line: DEPTH-stage shift register aligning issued pixels with the ROM read latency.
module pix_delay_line
  import sprite_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  pix_t pix_i,
  output pix_t pix_o
);
  pix_t [DEPTH-1:0] pipe_q, pipe_d;
  always_comb begin
    pipe_d[0] = pix_i;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clk) pipe_q <= !reset ? '0 : pipe_d;
  assign pix_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: one-sprite position keeper with rate-limited moves and erase/redraw pixel streams.
// Define SPRITE_MOVER_EDGE_CLAMP_EN to clamp illegal moves to the screen edge instead of flagging them.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int SPR_W    = 11,
  parameter int SPR_H    = 10,
  parameter int X_INIT   = 73,
  parameter int Y_INIT   = 105,
  parameter int STEP     = 5,
  parameter int ROM_LAT  = 2,
  parameter int HOLDOFF  = 25_000_000,
  localparam int AW      = $clog2(SPR_W * SPR_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          move_left,
  input  logic          move_right,
  output logic [AW-1:0] rom_addr,
  input  logic [2:0]    rom_data,
  output logic [7:0]    xout,
  output logic [6:0]    yout,
  output logic [2:0]    colourOut,
  output logic          drawEn,
  output logic [7:0]    xpos,
  output logic          busy,
  output logic          done,
  output logic          hit_edge
);
  localparam int CW = $clog2(SPR_W + 1);
  localparam int RW = $clog2(SPR_H + 1);
  localparam int TW = $clog2(HOLDOFF + ROM_LAT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);
  localparam logic [TW-1:0] LAT_LAST = TW'(ROM_LAT - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF - 1);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [8:0] XMAX9 = 9'(SCREEN_W - SPR_W);
  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic [7:0] X_INIT8 = 8'(X_INIT);
  localparam logic [6:0] Y_INIT7 = 7'(Y_INIT);
  if (X_INIT + SPR_W > SCREEN_W || Y_INIT + SPR_H > SCREEN_H) begin : g_geometry_check
    $error("sprite_mover: sprite does not fit on the screen");
  end
  state_t state_q, state_d;
  logic [7:0] xpos_q, xpos_d, ox_q, ox_d, step_x;
  logic [8:0] x9;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic hit_q, hit_d, busy_q, busy_d, done_q, done_d;
  logic last_col, last_pix, issue, step_ok;
  pix_t pix_in, pix_out;
  always_comb begin
    state_d = state_q;
    xpos_d = xpos_q;
    ox_d = ox_q;
    hit_d = hit_q;
    cnt_d = cnt_q;
    col_d = col_q;
    row_d = row_q;
    addr_d = addr_q;
    last_col = col_q == COL_LAST;
    last_pix = last_col && row_q == ROW_LAST;
    issue = state_q == ERASE || state_q == DRAW;
    x9 = {1'b0, xpos_q};
    step_ok = move_left ? x9 >= STEP9 : x9 + STEP9 <= XMAX9;
    step_x = move_left ? xpos_q - STEP8 : xpos_q + STEP8;
    // scan counters return to zero after the last pixel so the next stream starts clean
    if (issue) begin
      col_d = last_col ? '0 : col_q + 1'b1;
      row_d = last_pix ? '0 : last_col ? row_q + 1'b1 : row_q;
      addr_d = last_pix ? '0 : addr_q + 1'b1;
    end
    case (state_q)
      IDLE: if (start) begin
        state_d = DRAW;
        xpos_d = X_INIT8;
      end
      READY, EDGE: if (start) begin
        state_d = ERASE;
        ox_d = xpos_q;
        xpos_d = X_INIT8;
        hit_d = 1'b0;
      end else if (state_q == READY && (move_left || move_right)) begin
        ox_d = xpos_q;
`ifdef SPRITE_MOVER_EDGE_CLAMP_EN
        state_d = ERASE;
        xpos_d = step_ok ? step_x : move_left ? 8'd0 : XMAX9[7:0];
`else
        state_d = step_ok ? ERASE : EDGE;
        xpos_d = step_ok ? step_x : xpos_q;
        hit_d = !step_ok;
`endif
      end
      ERASE: state_d = last_pix ? DRAW : ERASE;
      DRAW: state_d = last_pix ? DRAIN : DRAW;
      DRAIN: begin
        state_d = cnt_q == LAT_LAST ? HOLD : DRAIN;
        cnt_d = cnt_q == LAT_LAST ? '0 : cnt_q + 1'b1;
      end
      HOLD: begin
        state_d = cnt_q == HOLD_LAST ? READY : HOLD;
        cnt_d = cnt_q == HOLD_LAST ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == ERASE || state_d == DRAW || state_d == DRAIN;
    done_d = state_q == DRAIN && state_d == HOLD;
  end
  always_comb begin
    pix_in.valid = issue;
    pix_in.x = (state_q == ERASE ? ox_q : xpos_q) + 8'(col_q);
    pix_in.y = Y_INIT7 + 7'(row_q);
    pix_in.erase = state_q == ERASE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      xpos_q <= X_INIT8;
      ox_q <= '0;
      hit_q <= 1'b0;
      cnt_q <= '0;
      col_q <= '0;
      row_q <= '0;
      addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xpos_q <= xpos_d;
      ox_q <= ox_d;
      hit_q <= hit_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
      row_q <= row_d;
      addr_q <= addr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  pix_delay_line #(.DEPTH(ROM_LAT)) u_delay (
    .clk  (clk),
    .reset(reset),
    .pix_i(pix_in),
    .pix_o(pix_out)
  );
  assign rom_addr = addr_q;
  assign xout = pix_out.x;
  assign yout = pix_out.y;
  assign colourOut = pix_out.erase ? COLOUR_BLACK : rom_data;
  assign drawEn = pix_out.valid;
  assign xpos = xpos_q;
  assign busy = busy_q;
  assign done = done_q;
  assign hit_edge = hit_q;
endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: directed-vector bench for sprite_mover with a two-cycle synchronous ROM model.
module tb_sprite_mover;
  localparam int N = 110;
  localparam int LAT = 2;
  localparam int HOLD = 8;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, move_left = 1'b0, move_right = 1'b0;
  logic [6:0] rom_addr, a1 = '0, a2 = '0;
  logic [2:0] rom_data, colourOut;
  logic [7:0] xout, xpos;
  logic [6:0] yout;
  logic drawEn, busy, done, hit_edge;
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_colour(input int a);
    return 3'((a * 5 + 3) % 8);
  endfunction

  always @(posedge clk) begin
    a1 <= rom_addr;
    a2 <= a1;
  end
  assign rom_data = rom_colour(int'(a2));

  sprite_mover #(
    .SCREEN_W(160), .SCREEN_H(120), .SPR_W(11), .SPR_H(10), .X_INIT(73), .Y_INIT(105),
    .STEP(5), .ROM_LAT(LAT), .HOLDOFF(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .move_left(move_left), .move_right(move_right),
    .rom_addr(rom_addr), .rom_data(rom_data), .xout(xout), .yout(yout), .colourOut(colourOut),
    .drawEn(drawEn), .xpos(xpos), .busy(busy), .done(done), .hit_edge(hit_edge)
  );

  // Caller drives the command at a negedge; the next posedge is the acceptance edge.
  task automatic run_stream(input string nm, input int t, input bit er, input int ox, input int nx);
    int p, q, xe, ye;
    logic [2:0] ce;
    bit de;
    @(posedge clk);
    for (int j = 0; j <= t + LAT; j++) begin
      @(negedge clk);
      if (j == 0) {start, move_left, move_right} = 3'b000;
      de = j >= LAT && j < t + LAT;
      vectors++;
      if (drawEn !== de) begin
        errors++;
        $display("FAIL %s drawEn cycle %0d: got %b want %b", nm, j, drawEn, de);
      end
      vectors++;
      if (busy !== (j < t + LAT)) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b want %b", nm, j, busy, j < t + LAT);
      end
      vectors++;
      if (done !== (j == t + LAT)) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b want %b", nm, j, done, j == t + LAT);
      end
      if (de) begin
        p = j - LAT;
        q = (er && p >= N) ? p - N : p;
        xe = ((er && p < N) ? ox : nx) + q % 11;
        ye = 105 + q / 11;
        ce = (er && p < N) ? 3'd0 : rom_colour(q);
        vectors++;
        if (xout !== 8'(xe) || yout !== 7'(ye) || colourOut !== ce) begin
          errors++;
          $display("FAIL %s pixel %0d: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                   nm, p, xout, yout, colourOut, xe, ye, ce);
        end
      end
    end
    vectors++;
    if (xpos !== 8'(nx)) begin
      errors++;
      $display("FAIL %s xpos: got %0d want %0d", nm, xpos, nx);
    end
  endtask

  task automatic wait_ready;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (drawEn !== 1'b0) begin errors++; $display("FAIL reset drawEn: got %b want 0", drawEn); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    vectors++;
    if (hit_edge !== 1'b0) begin errors++; $display("FAIL reset hit_edge: got %b want 0", hit_edge); end
    vectors++;
    if (xpos !== 8'd73) begin errors++; $display("FAIL reset xpos: got %0d want 73", xpos); end
    reset = 1'b1;
  endtask

  task automatic test_start;
    start = 1'b1;
    run_stream("start", N, 1'b0, 0, 73);
  endtask

  task automatic test_move_left;
    wait_ready();
    move_left = 1'b1;
    run_stream("move_left", 2 * N, 1'b1, 73, 68);
  endtask

  task automatic test_both;
    wait_ready();
    move_left = 1'b1;
    move_right = 1'b1;
    run_stream("both", 2 * N, 1'b1, 68, 63);
  endtask

  task automatic test_holdoff;
    move_right = 1'b1;
    repeat (HOLD) @(negedge clk);
    move_right = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL hold_ignored busy: got %b want 0", busy); end
    vectors++;
    if (xpos !== 8'd63) begin errors++; $display("FAIL hold_ignored xpos: got %0d want 63", xpos); end
    move_right = 1'b1;
    run_stream("right_after_hold", 2 * N, 1'b1, 63, 68);
    move_right = 1'b1;
    repeat (HOLD) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL held_early busy: got %b want 0", busy); end
    run_stream("held_right", 2 * N, 1'b1, 68, 73);
  endtask

  task automatic test_walk_left;
    for (int i = 0; i < 14; i++) begin
      wait_ready();
      move_left = 1'b1;
      run_stream("walk_left", 2 * N, 1'b1, 73 - 5 * i, 68 - 5 * i);
    end
  endtask

  task automatic test_edge;
    wait_ready();
    move_left = 1'b1;
`ifdef SPRITE_MOVER_EDGE_CLAMP_EN
    run_stream("clamp_left", 2 * N, 1'b1, 3, 0);
    vectors++;
    if (hit_edge !== 1'b0) begin errors++; $display("FAIL clamp hit_edge: got %b want 0", hit_edge); end
`else
    @(posedge clk);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      move_left = 1'b0;
      move_right = j >= 4;
      vectors++;
      if ({drawEn, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL edge_quiet cycle %0d: got drawEn/busy/done %b want 000", j, {drawEn, busy, done});
      end
    end
    move_right = 1'b0;
    vectors++;
    if (hit_edge !== 1'b1) begin errors++; $display("FAIL edge hit_edge: got %b want 1", hit_edge); end
    vectors++;
    if (xpos !== 8'd3) begin errors++; $display("FAIL edge xpos: got %0d want 3", xpos); end
    start = 1'b1;
    run_stream("edge_restart", 2 * N, 1'b1, 3, 73);
    vectors++;
    if (hit_edge !== 1'b0) begin errors++; $display("FAIL edge_restart hit_edge: got %b want 0", hit_edge); end
`endif
  endtask

  task automatic test_reset_mid;
    wait_ready();
    move_right = 1'b1;
    @(posedge clk);
    @(negedge clk);
    move_right = 1'b0;
    repeat (N + 30) @(negedge clk);
    vectors++;
    if (drawEn !== 1'b1) begin errors++; $display("FAIL mid_draw drawEn: got %b want 1", drawEn); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    vectors++;
    if (drawEn !== 1'b0) begin errors++; $display("FAIL reset_mid drawEn: got %b want 0", drawEn); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b want 0", busy); end
    vectors++;
    if (xpos !== 8'd73) begin errors++; $display("FAIL reset_mid xpos: got %0d want 73", xpos); end
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      vectors++;
      if ({drawEn, busy} !== 2'b00) begin
        errors++;
        $display("FAIL reset_stray cycle %0d: got drawEn/busy %b want 00", j, {drawEn, busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_move_left();
    test_both();
    test_holdoff();
    test_walk_left();
    test_edge();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/sprite_mover.md
# sprite_mover

Parametrised sprite engine that keeps one sprite's position, accepts left/right move commands with a rate-limit holdoff, and emits erase-then-redraw pixel streams for the VGA adapter. It sits between the game control FSM and the VGA adapter, and reads sprite colours from an external synchronous ROM whose read latency is configurable. It generalises the fixed 11x10 rocket mover to any sprite size, step, screen size and ROM latency, and adds selectable edge handling.

## Interface
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- SPR_W, 11, sprite width
- SPR_H, 10, sprite height
- X_INIT, 73, reset/start x of the sprite's top-left corner
- Y_INIT, 105, fixed y of the sprite's top-left corner
- STEP, 5, pixels moved per command
- ROM_LAT, 2, ROM address-to-data latency in cycles (≥1)
- HOLDOFF, 25_000_000, cycles after done during which commands are ignored
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  (re)initialise the position and draw the sprite
- move_left  in  1  level command
- move_right  in  1  level command
- rom_addr  out  AW=$clog2(SPR_W*SPR_H)  row*SPR_W+col
- rom_data  in  3  colour, valid ROM_LAT cycles after rom_addr
- xout  out  8  pixel x
- yout  out  7  pixel y
- colourOut  out  3  pixel colour
- drawEn  out  1  pixel write strobe
- xpos  out  8  current sprite x
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hit_edge  out  1  sticky edge flag (flag mode only)

## Operation
- Reset values: state IDLE, xpos=X_INIT, every output and pipeline valid bit 0, holdoff counter 0.
- States:
  - IDLE, on start → DRAW.
  - DRAW, issues N=SPR_W*SPR_H ROM reads, then → DRAIN.
  - READY, waits for a command.
  - ERASE, issues N black pixels at the old x, then → DRAW at the new x.
  - DRAIN, ROM_LAT cycles, then → HOLD.
  - HOLD, counts HOLDOFF cycles, then → READY.
  - EDGE.
- Scan order: row-major. The column wraps at SPR_W−1 to 0 and increments the row. The final pixel is (x+SPR_W−1, Y_INIT+SPR_H−1).
- Every issued pixel enters a ROM_LAT-deep delay line with its x, y and erase tag. The output colour is 0 when the erase tag is set, otherwise rom_data. drawEn is the delayed valid.
- ERASE and DRAW stream back-to-back with no gap. The stream order is preserved.
- Commands are sampled only in READY.
  - Left has priority when both commands are high.
  - start in READY or EDGE sets xpos=X_INIT, clears hit_edge and goes to ERASE (erase the old position, draw at X_INIT).
  - start has priority over moves.
- Edge rules:
  - Left is illegal if xpos < STEP.
  - Right is illegal if xpos+STEP+SPR_W > SCREEN_W.
  - A legal move sets xpos ± STEP, latched on the acceptance cycle.
- Commands during a non-READY state are ignored, not queued.
- Arithmetic is done 9 bits wide internally. xpos is always within 0..SCREEN_W−SPR_W.

## Timing
- Move accepted at clock edge k:
  - busy rises at k+1.
  - Issue cycles run k+1..k+2N.
  - drawEn is high for cycles k+1+ROM_LAT..k+2N+ROM_LAT (the first N pixels are erase).
  - done pulses at k+2N+ROM_LAT+1, and busy falls in the same cycle.
- start from IDLE: same timing with N instead of 2N.
- Commands are honoured again HOLDOFF cycles after done.
- Reset mid-operation takes effect at the next edge: drawEn is low, the pipeline is flushed and xpos=X_INIT. No partial stream resumes.

## Configuration
- SPRITE_MOVER_EDGE_CLAMP_EN defined:
  - An illegal move clamps xpos to 0 or SCREEN_W−SPR_W and performs the full erase+draw.
  - hit_edge stays 0.
- Undefined (flag mode):
  - An illegal move sets hit_edge and enters EDGE. No pixels are issued and done is not pulsed.
  - The block leaves EDGE only on start or reset.

## Structure
- sprite_pkg holds:
  - the state enum,
  - the colour typedef (logic [2:0]),
  - the COLOUR_BLACK constant,
  - the default screen dimensions.
- Sub-module pix_delay_line, parameter DEPTH=ROM_LAT: a shift register of {valid, x, y, erase}, cleared by reset.

## Test plan
- Reset, then start → exactly 110 drawEn cycles covering x 73..83, y 105..114; colours match the ROM; done at cycle 113; xpos=73.
- move_left from x=73 → 110 black pixels at x 73..83, then 110 ROM pixels at x 68..78; xpos=68; done after 2N+3=223 cycles.
- move_left and move_right high together in READY → left taken, xpos −5.
- Command during HOLD (HOLDOFF=8 in the bench) → ignored; a command held past 8 cycles → accepted.
- xpos=3, then move_left:
  - flag mode → hit_edge=1, no drawEn, stuck in EDGE; start → xpos=73, hit_edge=0.
  - clamp mode → xpos=0, full erase+draw.
- Reset asserted mid-DRAW → the next cycle has drawEn=0, busy=0, xpos=73, and no stray pixels afterwards.
